// File: rtl/imem_boot_loader_pkg.sv
// Shared types and defaults for the serial instruction-memory boot loader.
// Holds the FSM encoding and the default frame marker and inter-byte timeout.
package imem_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
  localparam int         TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // States that sit inside a frame: bytes are consumed and the timeout runs.
  function automatic logic in_frame(state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the boot loader.
// Handshake: rx_valid is a strobe without ready; every cycle it is high exactly one byte is consumed.
interface imem_boot_loader_if
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  load_done;
  logic                  load_err;
  logic                  busy;
  state_t                dbg_state;

  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err, busy, dbg_state
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err, busy, dbg_state
  );
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_ready flags the 4th byte
// combinationally so the parent can register the write on the accepting edge.
module imem_boot_loader_byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_ready,
  output logic [31:0] word_next
);
  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  assign word_next  = {shift_q, byte_data};
  assign word_ready = byte_valid && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      idx_q   <= idx_q + 2'd1;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Serial program loader: parses SYNC/CNT/data/CHK frames, writes words into
// instruction memory and holds the core in reset until a checksum-valid image lands.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clk,
  input logic rst,
  imem_boot_loader_if.master bus
);
  localparam int          IW  = ADDR_WIDTH + 1;
  localparam int          TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

  state_t                state, state_n;
  logic [7:0]            cnt_hi;
  logic [15:0]           cnt;
  logic [7:0]            csum;
  logic [IW-1:0]         widx;
  logic [TW-1:0]         tmo;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic        frame_active, frame_start, timeout, pack_en, word_ready, last_word;
  logic [31:0] word_next;
  logic [15:0] cnt_rx;

  assign frame_active = in_frame(state);
  assign frame_start  = bus.rx_valid && (bus.rx_data == SYNC_BYTE) && !frame_active;
  assign timeout      = frame_active && !bus.rx_valid && (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign pack_en      = (state == ST_DATA) && bus.rx_valid;
  assign cnt_rx       = {cnt_hi, bus.rx_data};
  // Word index is one bit wider than the address so a full-capacity image compares cleanly.
  assign last_word    = (16'(widx) + 16'd1) == cnt;

  imem_boot_loader_byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (frame_start),
    .byte_valid (pack_en),
    .byte_data  (bus.rx_data),
    .word_ready (word_ready),
    .word_next  (word_next)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (frame_start) state_n = ST_LEN_HI;
      ST_LEN_HI: if (bus.rx_valid) state_n = ST_LEN_LO;
      ST_LEN_LO: begin
        if (bus.rx_valid) begin
          if ({1'b0, cnt_rx} > CAP)  state_n = ST_ERR;
          else if (cnt_rx == 16'd0)  state_n = ST_CHK;
          else                       state_n = ST_DATA;
        end
      end
      ST_DATA: if (word_ready && last_word) state_n = ST_CHK;
      ST_CHK: if (bus.rx_valid) state_n = (bus.rx_data == csum) ? ST_DONE : ST_ERR;
      default: state_n = ST_IDLE;
    endcase
    // A byte on the threshold cycle suppresses the timeout (timeout requires !rx_valid).
    if (timeout) state_n = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_hi  <= '0;
      cnt     <= '0;
      csum    <= '0;
      widx    <= '0;
      tmo     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      we_q  <= word_ready;
      tmo   <= (frame_active && !bus.rx_valid) ? tmo + TW'(1) : '0;
      if (word_ready) begin
        addr_q  <= widx[ADDR_WIDTH-1:0];
        wdata_q <= word_next;
        widx    <= widx + IW'(1);
      end
      if ((state == ST_LEN_HI) && bus.rx_valid) cnt_hi <= bus.rx_data;
      if ((state == ST_LEN_LO) && bus.rx_valid) cnt <= cnt_rx;
      if (pack_en) csum <= csum ^ bus.rx_data;
      if (frame_start) begin
        csum <= '0;
        widx <= '0;
      end
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = (state != ST_DONE);
  assign bus.load_done  = (state == ST_DONE);
  assign bus.load_err   = (state == ST_ERR);
  assign bus.busy       = frame_active;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a wide (256-word) and a narrow (4-word) loader share
// one byte stream; a byte-offset frame model predicts status and writes every cycle.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int TMO = 16;

  logic       tb_clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       chk_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tb_clk = ~tb_clk;

  imem_boot_loader_if #(.ADDR_WIDTH(8)) bus_a ();
  imem_boot_loader_if #(.ADDR_WIDTH(2)) bus_b ();

  assign bus_a.rx_valid = rx_valid;
  assign bus_a.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid;
  assign bus_b.rx_data  = rx_data;

  imem_boot_loader #(.ADDR_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(tb_clk), .rst(rst), .bus(bus_a.master));
  imem_boot_loader #(.ADDR_WIDTH(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(tb_clk), .rst(rst), .bus(bus_b.master));

  // ---------------- frame model (per instance: 0 = wide, 1 = narrow) ----------------
  int          m_cap[2] = '{256, 4};
  bit          m_active[2];
  int          m_pos[2];
  int          m_cnt[2];
  int          m_idle[2];
  logic [7:0]  m_x[2];
  logic [31:0] m_word[2];
  logic        m_done[2], m_err[2], m_crst[2], m_we[2];
  logic [39:0] exp_q_a[$];
  logic [39:0] exp_q_b[$];

  logic [31:0] mem_a[256];
  logic [31:0] mem_b[4];
  int          wr_cnt[2] = '{0, 0};

  task automatic fail_frame(input int i);
    m_active[i] = 0; m_err[i] = 1; m_done[i] = 0; m_crst[i] = 1;
  endtask

  task automatic model_step(input int i);
    int k;
    m_we[i] = 0;
    if (rst) begin
      m_active[i] = 0; m_done[i] = 0; m_err[i] = 0; m_crst[i] = 1;
    end else if (!m_active[i]) begin
      if (rx_valid && rx_data == 8'hA5) begin
        m_active[i] = 1; m_pos[i] = 0; m_x[i] = 0; m_idle[i] = 0;
        m_done[i] = 0; m_err[i] = 0; m_crst[i] = 1;
      end
    end else if (rx_valid) begin
      m_idle[i] = 0;
      if (m_pos[i] == 0) begin
        m_cnt[i] = int'(rx_data) * 256; m_pos[i] = 1;
      end else if (m_pos[i] == 1) begin
        m_cnt[i] = m_cnt[i] + int'(rx_data);
        if (m_cnt[i] > m_cap[i]) fail_frame(i);
        else m_pos[i] = 2;
      end else if (m_pos[i] < 2 + 4 * m_cnt[i]) begin
        k = m_pos[i] - 2;
        m_word[i] = {m_word[i][23:0], rx_data};
        m_x[i] = m_x[i] ^ rx_data;
        if (k % 4 == 3) begin
          m_we[i] = 1;
          if (i == 0) exp_q_a.push_back({8'(k / 4), m_word[i]});
          else        exp_q_b.push_back({8'(k / 4), m_word[i]});
        end
        m_pos[i] = m_pos[i] + 1;
      end else begin
        if (rx_data == m_x[i]) begin
          m_active[i] = 0; m_done[i] = 1; m_crst[i] = 0;
        end else fail_frame(i);
      end
    end else begin
      m_idle[i] = m_idle[i] + 1;
      if (m_idle[i] == TMO) fail_frame(i);
    end
  endtask

  always @(posedge tb_clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic dn, input logic er,
                          input logic cr, input logic bs);
    logic [39:0] e;
    string       sfx;
    sfx = (i == 0) ? "_a" : "_b";
    check({"load_done", sfx}, 32'(dn), 32'(m_done[i]));
    check({"load_err", sfx},  32'(er), 32'(m_err[i]));
    check({"core_rst", sfx},  32'(cr), 32'(m_crst[i]));
    check({"busy", sfx},      32'(bs), 32'(m_active[i]));
    check({"imem_we", sfx},   32'(we), 32'(m_we[i]));
    if (we === 1'b1) begin
      wr_cnt[i]++;
      if (i == 0) mem_a[addr] = wd;
      else        mem_b[addr[1:0]] = wd;
      if ((i == 0 && exp_q_a.size() == 0) || (i == 1 && exp_q_b.size() == 0)) begin
        check({"unexpected_write", sfx}, 32'(addr), 32'hFFFF_FFFF);
      end else begin
        e = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
        check({"imem_addr", sfx},  32'(addr), 32'(e[39:32]));
        check({"imem_wdata", sfx}, wd, e[31:0]);
      end
    end
  endtask

  always @(negedge tb_clk) begin
    if (chk_on) begin
      cmp_inst(0, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
               bus_a.load_done, bus_a.load_err, bus_a.core_rst, bus_a.busy);
      cmp_inst(1, bus_b.imem_we, 8'(bus_b.imem_addr), bus_b.imem_wdata,
               bus_b.load_done, bus_b.load_err, bus_b.core_rst, bus_b.busy);
    end
  end

  // ---------------- driver ----------------
  logic [7:0] tx_q[$];

  task automatic drive(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic send(input int gap);
    logic [7:0] b;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      drive(1'b1, b);
      idle(gap);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00);
    chk_on = 1'b1;
    drive(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  // Checksum of 20 08 00 7B AC 08 00 04 is F3.
  task automatic push_prog(input logic [7:0] chk);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h7B,
             8'hAC, 8'h08, 8'h00, 8'h04, chk};
  endtask

  task automatic push_counted(input int cnt);
    logic [7:0] x;
    x = 8'h00;
    tx_q = '{8'hA5, 8'h00, 8'(cnt)};
    for (int n = 1; n <= 4 * cnt; n++) begin
      tx_q.push_back(8'(n));
      x = x ^ 8'(n);
    end
    tx_q.push_back(x);
  endtask

  initial begin
    int w0, w1;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    do_reset();
    check("rst_we",    32'(bus_a.imem_we),    32'd0);
    check("rst_addr",  32'(bus_a.imem_addr),  32'd0);
    check("rst_wdata", bus_a.imem_wdata,      32'd0);
    check("rst_crst",  32'(bus_a.core_rst),   32'd1);
    check("rst_done",  32'(bus_a.load_done),  32'd0);
    check("rst_err",   32'(bus_a.load_err),   32'd0);
    check("rst_busy",  32'(bus_a.busy),       32'd0);
    check("rst_state", 32'(bus_a.dbg_state),  32'(ST_IDLE));

    // Two-word program with a gap between bytes.
    push_prog(8'hF3); send(1); idle(2);
    check("t1_done",  32'(bus_a.load_done), 32'd1);
    check("t1_crst",  32'(bus_a.core_rst),  32'd0);
    check("t1_mem0",  mem_a[0], 32'h2008007B);
    check("t1_mem1",  mem_a[1], 32'hAC080004);
    check("t1_nwr",   32'(wr_cnt[0]), 32'd2);
    check("t1_done_b", 32'(bus_b.load_done), 32'd1);

    // Same program, bad checksum.
    push_prog(8'h00); send(1); idle(2);
    check("t2_err",  32'(bus_a.load_err),  32'd1);
    check("t2_crst", 32'(bus_a.core_rst),  32'd1);
    check("t2_done", 32'(bus_a.load_done), 32'd0);

    // Junk before SYNC is ignored, then a normal load.
    w0 = wr_cnt[0];
    tx_q = '{8'h00, 8'hFF, 8'h13}; send(1); idle(1);
    check("t3_nowr", 32'(wr_cnt[0]), 32'(w0));
    check("t3_err_held", 32'(bus_a.load_err), 32'd1);
    push_prog(8'hF3); send(0); idle(2);
    check("t3_done", 32'(bus_a.load_done), 32'd1);

    // Zero-length frame: checksum of nothing is 00.
    w0 = wr_cnt[0];
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00}; send(0); idle(1);
    check("zero_done", 32'(bus_a.load_done), 32'd1);
    check("zero_nowr", 32'(wr_cnt[0]), 32'(w0));

    // Timeout: stall after two data bytes.
    w0 = wr_cnt[0];
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34}; send(0);
    idle(TMO - 1);
    check("t4_busy_pre", 32'(bus_a.busy), 32'd1);
    idle(1);
    check("t4_err",  32'(bus_a.load_err), 32'd1);
    check("t4_busy", 32'(bus_a.busy),     32'd0);
    check("t4_nowr", 32'(wr_cnt[0]), 32'(w0));

    // CNT=5 overflows the 4-word loader right after CNT_LO.
    w1 = wr_cnt[1];
    push_counted(5);
    for (int n = 0; n < 3; n++) drive(1'b1, tx_q.pop_front());
    check("t5_err_b",  32'(bus_b.load_err), 32'd1);
    check("t5_busy_a", 32'(bus_a.busy),     32'd1);
    send(0); idle(2);
    check("t5_nowr_b", 32'(wr_cnt[1]), 32'(w1));
    check("t5_done_a", 32'(bus_a.load_done), 32'd1);
    push_counted(4); send(1); idle(2);
    check("t5_wr4_b",  32'(wr_cnt[1] - w1), 32'd4);
    check("t5_mem0_b", mem_b[0], 32'h01020304);
    check("t5_mem3_b", mem_b[3], 32'h0D0E0F10);
    check("t5_done_b", 32'(bus_b.load_done), 32'd1);

    // Reset mid-frame, then reload with gaps and back-to-back.
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08}; send(0);
    rst = 1'b1; drive(1'b0, 8'h00); rst = 1'b0;
    check("t6_busy",  32'(bus_a.busy),      32'd0);
    check("t6_crst",  32'(bus_a.core_rst),  32'd1);
    check("t6_done",  32'(bus_a.load_done), 32'd0);
    check("t6_err",   32'(bus_a.load_err),  32'd0);
    check("t6_addr",  32'(bus_a.imem_addr), 32'd0);
    check("t6_wdata", bus_a.imem_wdata,     32'd0);
    mem_a[0] = '0; mem_a[1] = '0;
    push_prog(8'hF3); send(1); idle(2);
    check("t6_mem0", mem_a[0], 32'h2008007B);
    check("t6_mem1", mem_a[1], 32'hAC080004);
    w0 = wr_cnt[0];
    push_prog(8'hF3); send(0); idle(2);
    check("t6_b2b_done", 32'(bus_a.load_done), 32'd1);
    check("t6_b2b_nwr",  32'(wr_cnt[0] - w0), 32'd2);

    check("expq_a_empty", 32'(exp_q_a.size()), 32'd0);
    check("expq_b_empty", 32'(exp_q_b.size()), 32'd0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
